// File: rtl/bus_signal_pipe_if.sv
// bus_signal_pipe_if: source/consumer bundle for bus_signal_pipe
//   in_data/in_sel/in_mode/in_valid/in_ready : source side handshake
//   out_data/out_valid/out_ready             : consumer side handshake
//   xfer_count                               : completed output transfers
//   master = the environment driving the block, slave = the block itself
interface bus_signal_pipe_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int CNT_W    = 8
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]          in_sel;
    logic [1:0]                in_mode;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CNT_W-1:0]          xfer_count;

    modport master (
        output in_data, in_sel, in_mode, in_valid, out_ready,
        input  in_ready, out_data, out_valid, xfer_count
    );

    modport slave (
        input  in_data, in_sel, in_mode, in_valid, out_ready,
        output in_ready, out_data, out_valid, xfer_count
    );
endinterface

// File: rtl/bus_signal_pipe.sv
// bus_signal_pipe: combines CHANNELS buses (select/AND/OR/XOR) into a 2-entry valid/ready buffer
//   clk, rst_n (async, active-low)
//   bus.in_*  : combine operands, mode and source handshake
//   bus.out_* : registered result and consumer handshake
//   bus.xfer_count : pop counter, wraps modulo 2^CNT_W
module bus_signal_pipe #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int CNT_W    = 8
) (
    input logic              clk,
    input logic              rst_n,
    bus_signal_pipe_if.slave bus
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] ch, sel_res, and_res, or_res, xor_res, result;
    logic             in_ready, out_valid, accept, pop;

    assign sel       = bus.in_sel;
    assign in_ready  = state_q != TWO;
    assign out_valid = state_q != EMPTY;
    assign accept    = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    // An out-of-range select never matches a channel, so it leaves zeros.
    always_comb begin
        ch      = '0;
        sel_res = '0;
        and_res = '1;
        or_res  = '0;
        xor_res = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            ch      = bus.in_data[k*WIDTH +: WIDTH];
            and_res = and_res & ch;
            or_res  = or_res | ch;
            xor_res = xor_res ^ ch;
            sel_res = (int'(sel) == k) ? ch : sel_res;
        end
        result = bus.in_mode == 2'b00 ? sel_res :
                 bus.in_mode == 2'b01 ? and_res :
                 bus.in_mode == 2'b10 ? or_res  : xor_res;
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q + CNT_W'(pop);
        case (state_q)
            EMPTY: begin
                main_d  = accept ? result : main_q;
                state_d = accept ? ONE : EMPTY;
            end
            ONE: begin
                main_d  = (accept & pop) ? result : main_q;
                skid_d  = (accept & ~pop) ? result : skid_q;
                state_d = (accept & ~pop) ? TWO : (~accept & pop) ? EMPTY : ONE;
            end
            TWO: begin
                main_d  = pop ? skid_q : main_q;
                state_d = pop ? ONE : TWO;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = main_q;
    assign bus.xfer_count = cnt_q;
endmodule

// File: tb/tb_bus_signal_pipe.sv
// tb_bus_signal_pipe: lockstep 2- and 3-channel instances checked against a FIFO reference model
module tb_bus_signal_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   pops = 0;
    logic [3:0] q2[$];
    logic [3:0] q3[$];
    logic [3:0] shown2 = '0;
    logic [3:0] shown3 = '0;
    logic        cv, cr;
    logic [1:0]  cs, cm;
    logic [11:0] cd;

    always #5 clk = ~clk;

    bus_signal_pipe_if #(.WIDTH(4), .CHANNELS(2)) if2 ();
    bus_signal_pipe_if #(.WIDTH(4), .CHANNELS(3)) if3 ();

    bus_signal_pipe #(.WIDTH(4), .CHANNELS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    bus_signal_pipe #(.WIDTH(4), .CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] combine(input logic [11:0] d, input int nch, input int s, input logic [1:0] m);
        logic [3:0] r, v;
        if (m == 2'b00) return (s < nch) ? 4'((d >> (s * 4)) & 12'hF) : 4'h0;
        r = (m == 2'b01) ? 4'hF : 4'h0;
        for (int k = 0; k < nch; k++) begin
            v = 4'((d >> (k * 4)) & 12'hF);
            r = (m == 2'b01) ? (r & v) : (m == 2'b10) ? (r | v) : (r ^ v);
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] m, input logic [11:0] d, input logic r);
        cv = v; cs = s; cm = m; cd = d; cr = r;
        if2.in_valid = v; if2.in_sel = s[0]; if2.in_mode = m; if2.in_data = d[7:0]; if2.out_ready = r;
        if3.in_valid = v; if3.in_sel = s;    if3.in_mode = m; if3.in_data = d;      if3.out_ready = r;
    endtask

    task automatic check_all();
        check("rdy2", if2.in_ready, q2.size() < 2);
        check("rdy3", if3.in_ready, q3.size() < 2);
        check("vld2", if2.out_valid, q2.size() > 0);
        check("vld3", if3.out_valid, q3.size() > 0);
        check("data2", if2.out_data, shown2);
        check("data3", if3.out_data, shown3);
        check("cnt2", if2.xfer_count, pops % 256);
        check("cnt3", if3.xfer_count, pops % 256);
    endtask

    task automatic model_reset();
        q2.delete(); q3.delete();
        shown2 = '0; shown3 = '0; pops = 0;
    endtask

    // One clock: drive at the falling edge, advance the model on the rising edge, check on the next falling edge.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [1:0] m, input logic [11:0] d, input logic r);
        logic acc, pp;
        drive(v, s, m, d, r);
        @(posedge clk);
        acc = v && q2.size() < 2;
        pp  = r && q2.size() > 0;
        if (pp) begin
            void'(q2.pop_front());
            void'(q3.pop_front());
            pops++;
        end
        if (acc) begin
            q2.push_back(combine(d, 2, int'(s[0]), m));
            q3.push_back(combine(d, 3, int'(s), m));
        end
        if (q2.size() > 0) shown2 = q2[0];
        if (q3.size() > 0) shown3 = q3[0];
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int guard;
        drive(1'b0, 2'd0, 2'd0, 12'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_vld", if2.out_valid, 1'b0);
        check("rst_rdy", if2.in_ready, 1'b1);
        check("rst_data", if2.out_data, 4'h0);
        check("rst_cnt", if2.xfer_count, 8'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        cycle(1'b1, 2'd1, 2'b00, 12'h0EB, 1'b1);
        check("sel_data", if2.out_data, 4'b1110);
        check("sel_vld", if2.out_valid, 1'b1);
        cycle(1'b0, 2'd0, 2'b00, 12'h0EB, 1'b1);
        check("sel_pulse", if2.out_valid, 1'b0);
        check("sel_cnt", if2.xfer_count, 8'd1);

        cycle(1'b1, 2'd0, 2'b01, 12'h0EB, 1'b1);
        check("and", if2.out_data, 4'b1010);
        cycle(1'b1, 2'd0, 2'b10, 12'h0EB, 1'b1);
        check("or", if2.out_data, 4'b1111);
        cycle(1'b1, 2'd0, 2'b11, 12'h0EB, 1'b1);
        check("xor", if2.out_data, 4'b0101);
        cycle(1'b0, 2'd0, 2'b00, 12'h0EB, 1'b1);
        check("mode_cnt", if2.xfer_count, 8'd4);

        cycle(1'b1, 2'd0, 2'b00, 12'h001, 1'b0);
        check("stall1_rdy", if2.in_ready, 1'b1);
        cycle(1'b1, 2'd0, 2'b00, 12'h002, 1'b0);
        check("stall2_rdy", if2.in_ready, 1'b0);
        check("stall2_data", if2.out_data, 4'h1);
        cycle(1'b1, 2'd0, 2'b00, 12'h003, 1'b0);
        check("stall3_data", if2.out_data, 4'h1);
        cycle(1'b1, 2'd0, 2'b00, 12'h003, 1'b1);
        check("drain1_data", if2.out_data, 4'h2);
        check("drain1_rdy", if2.in_ready, 1'b1);
        cycle(1'b1, 2'd0, 2'b00, 12'h003, 1'b1);
        check("drain2_data", if2.out_data, 4'h3);
        cycle(1'b0, 2'd0, 2'b00, 12'h000, 1'b1);
        check("drain3_vld", if2.out_valid, 1'b0);

        cycle(1'b1, 2'd3, 2'b00, 12'hABC, 1'b1);
        check("oor_sel3", if3.out_data, 4'h0);
        cycle(1'b1, 2'd0, 2'b11, 12'h348, 1'b1);
        check("xor3", if3.out_data, 4'hF);
        cycle(1'b0, 2'd0, 2'b00, 12'h000, 1'b1);

        guard = 0;
        while (pops < 256 && guard < 400) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 12'($urandom), 1'b1);
            guard++;
        end
        check("wrap_reached", pops, 256);
        check("wrap0", if2.xfer_count, 8'd0);
        cycle(1'b1, 2'd0, 2'b00, 12'h005, 1'b1);
        check("wrap1", if2.xfer_count, 8'd1);

        cycle(1'b1, 2'd0, 2'b00, 12'h009, 1'b0);
        check("two_rdy", if2.in_ready, 1'b0);
        drive(1'b0, 2'd0, 2'b00, 12'h000, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_vld", if2.out_valid, 1'b0);
        check("mid_rst_rdy", if2.in_ready, 1'b1);
        check("mid_rst_data", if2.out_data, 4'h0);
        check("mid_rst_cnt", if2.xfer_count, 8'h0);
        check("mid_rst_data3", if3.out_data, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 2'd0, 2'b00, 12'h006, 1'b0);
        check("post_rst_data", if2.out_data, 4'h6);
        cycle(1'b0, 2'd0, 2'b00, 12'h000, 1'b1);
        check("post_rst_vld", if2.out_valid, 1'b0);
        check("post_rst_cnt", if2.xfer_count, 8'd1);

        for (int i = 0; i < 600; i++) begin
            if (cv && q2.size() == 2)
                cycle(cv, cs, cm, cd, 1'($urandom));
            else
                cycle(1'($urandom), 2'($urandom), 2'($urandom), 12'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
